// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
//
// Purpose:
//   Multi-cycle WIDTH-bit add/subtract built around one 8-bit slice adder.
//   The slices are processed LSB first, and the carry ripples between them
//   through a register. Subtraction is computed as A + ~B + 1. The flags
//   follow MIPS signed-overflow semantics.
//
// Handshake:
//   An operation is accepted on a rising edge where start_valid && start_ready.
//   start_ready is high only in IDLE. A requester holding start_valid while
//   the block is busy is simply not accepted, and this has no side effects.
//   done is a one-cycle registered pulse. result, carry_out and overflow are
//   stable from done until the next accept edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   start_valid  requester presents an operation
//   start_ready  block can accept (IDLE only)
//   op_a, op_b   operands, sampled only at the accept edge
//   sub          0 = A+B, 1 = A-B
//   result       sum/difference (WIDTH bits, modulo 2^WIDTH)
//   carry_out    final slice carry (sub: 1 = no borrow)
//   overflow     signed two's-complement overflow
//   done         one-cycle pulse when result/flags are valid
//   busy         high in RUN and DONE
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 DONE)

module byte_serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NSLICE = WIDTH / 8;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;        // B already inverted for subtraction
    logic               carry_q;
    logic [IDXW-1:0]    idx_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_out_q;
    logic               overflow_q;
    logic               done_q;
    logic               busy_q;

    logic               accept;
    logic               last_slice;
    logic [7:0]         a_slice;
    logic [7:0]         b_slice;
    logic [8:0]         slice_sum;

    assign accept     = start_valid && start_ready;
    assign last_slice = (idx_q == IDXW'(NSLICE - 1));
    assign a_slice    = a_q[{idx_q, 3'b000} +: 8];
    assign b_slice    = b_q[{idx_q, 3'b000} +: 8];
    assign slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {8'd0, carry_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        start_ready = (state_q == S_IDLE);
        dbg_state   = state_q;
    end

    // Datapath and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // The pulse lasts exactly the DONE cycle. busy covers RUN and DONE.
            done_q <= (state_d == S_DONE);
            busy_q <= (state_d != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q      <= op_a;
                        b_q      <= sub ? ~op_b : op_b;
                        carry_q  <= sub;   // +1 completes the two's complement of B
                        idx_q    <= '0;
                        result_q <= '0;
                    end
                end
                S_RUN: begin
                    result_q[{idx_q, 3'b000} +: 8] <= slice_sum[7:0];
                    carry_q                        <= slice_sum[8];
                    if (last_slice) begin
                        // The top slice holds the sign bits. Overflow means the
                        // operand signs agree but the result sign differs.
                        carry_out_q <= slice_sum[8];
                        overflow_q  <= (a_slice[7] == b_slice[7]) &&
                                       (slice_sum[7] != a_slice[7]);
                        idx_q       <= '0;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
